// File: rtl/axi_lite_mem_arbiter.sv
// Purpose: N-master to 1-slave AXI4-lite arbiter, one transaction in flight, round-robin or fixed priority.
// Latency: one IDLE cycle to register the grant; ready/valid/response paths are combinational.
// Backpressure: slave ready/valid pass straight through to the owner; all other masters see 0.
module axi_lite_mem_arbiter #(
    parameter int NUM_MASTERS   = 2,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int PRIORITY_MODE = 0
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    // master side
    input  logic [NUM_MASTERS-1:0]                m_awvalid,
    input  logic [NUM_MASTERS-1:0]                m_wvalid,
    input  logic [NUM_MASTERS-1:0]                m_arvalid,
    input  logic [NUM_MASTERS-1:0]                m_bready,
    input  logic [NUM_MASTERS-1:0]                m_rready,
    output logic [NUM_MASTERS-1:0]                m_awready,
    output logic [NUM_MASTERS-1:0]                m_wready,
    output logic [NUM_MASTERS-1:0]                m_arready,
    output logic [NUM_MASTERS-1:0]                m_bvalid,
    output logic [NUM_MASTERS-1:0]                m_rvalid,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_awaddr,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_araddr,
    input  logic [NUM_MASTERS*3-1:0]              m_awprot,
    input  logic [NUM_MASTERS*3-1:0]              m_arprot,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_wdata,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]   m_wstrb,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_rdata,
    // slave side
    output logic                                  s_awvalid,
    output logic                                  s_wvalid,
    output logic                                  s_arvalid,
    output logic                                  s_bready,
    output logic                                  s_rready,
    input  logic                                  s_awready,
    input  logic                                  s_wready,
    input  logic                                  s_arready,
    input  logic                                  s_bvalid,
    input  logic                                  s_rvalid,
    output logic [ADDR_WIDTH-1:0]                 s_awaddr,
    output logic [ADDR_WIDTH-1:0]                 s_araddr,
    output logic [2:0]                            s_awprot,
    output logic [2:0]                            s_arprot,
    output logic [DATA_WIDTH-1:0]                 s_wdata,
    output logic [DATA_WIDTH/8-1:0]               s_wstrb,
    input  logic [DATA_WIDTH-1:0]                 s_rdata,
    // status
    output logic [2:0]                            grant_id,
    output logic                                  busy
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic [2:0] grant_q, grant_d;
    logic [2:0] ptr_q, ptr_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] gmask;
    logic                   arb_found;
    logic [2:0]             arb_winner;

    logic g_awvalid, g_wvalid, g_arvalid, g_bready, g_rready;
    logic aw_hs, w_hs;

    // Read data has a single source, so every master sees it; only the owner gets rvalid.
    assign m_rdata  = {NUM_MASTERS{s_rdata}};
    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);

    // Pick the winner among current requesters (round-robin from ptr+1, or lowest index).
    always_comb begin
        req        = m_awvalid | m_arvalid;
        arb_found  = 1'b0;
        arb_winner = '0;
        if (PRIORITY_MODE == 1) begin
            // Walk downward so the lowest requesting index is the last one written.
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (req[i]) begin
                    arb_found  = 1'b1;
                    arb_winner = 3'(i);
                end
            end
        end else begin
            for (int k = 1; k <= NUM_MASTERS; k++) begin
                if (!arb_found && req[(int'(ptr_q) + k) % NUM_MASTERS]) begin
                    arb_found  = 1'b1;
                    arb_winner = 3'((int'(ptr_q) + k) % NUM_MASTERS);
                end
            end
        end
    end

    // Select the owner's request signals and payload slices; payload follows grant_q in every state.
    always_comb begin
        gmask     = '0;
        g_awvalid = 1'b0;
        g_wvalid  = 1'b0;
        g_arvalid = 1'b0;
        g_bready  = 1'b0;
        g_rready  = 1'b0;
        s_awaddr  = '0;
        s_araddr  = '0;
        s_awprot  = '0;
        s_arprot  = '0;
        s_wdata   = '0;
        s_wstrb   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q == 3'(i)) begin
                gmask[i]  = 1'b1;
                g_awvalid = m_awvalid[i];
                g_wvalid  = m_wvalid[i];
                g_arvalid = m_arvalid[i];
                g_bready  = m_bready[i];
                g_rready  = m_rready[i];
                s_awaddr  = m_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_araddr  = m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_awprot  = m_awprot[i*3 +: 3];
                s_arprot  = m_arprot[i*3 +: 3];
                s_wdata   = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                s_wstrb   = m_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
            end
        end
    end

    // Transaction FSM: next state plus the handshake routing between owner and slave.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_arvalid = 1'b0;
        s_bready  = 1'b0;
        s_rready  = 1'b0;
        m_awready = '0;
        m_wready  = '0;
        m_arready = '0;
        m_bvalid  = '0;
        m_rvalid  = '0;

        unique case (state_q)
            IDLE: begin
                if (arb_found) begin
                    grant_d = arb_winner;
                    ptr_d   = arb_winner;
                    // A winner presenting both AW and AR is served as a write first.
                    if (m_awvalid[arb_winner]) begin
                        state_d = WR_ADDR;
                    end else begin
                        state_d = RD_ADDR;
                    end
                end
            end

            WR_ADDR: begin
                // AW and W are tracked independently so they may finish in any order.
                s_awvalid = g_awvalid & ~aw_done_q;
                s_wvalid  = g_wvalid & ~w_done_q;
                m_awready = (s_awready & ~aw_done_q) ? gmask : '0;
                m_wready  = (s_wready & ~w_done_q) ? gmask : '0;
                aw_hs     = s_awvalid & s_awready;
                w_hs      = s_wvalid & s_wready;
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d   = WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end

            WR_RESP: begin
                m_bvalid = s_bvalid ? gmask : '0;
                s_bready = g_bready;
                if (s_bvalid && s_bready) begin
                    state_d = IDLE;
                end
            end

            RD_ADDR: begin
                s_arvalid = g_arvalid;
                m_arready = s_arready ? gmask : '0;
                if (s_arvalid && s_arready) begin
                    state_d = RD_DATA;
                end
            end

            RD_DATA: begin
                m_rvalid = s_rvalid ? gmask : '0;
                s_rready = g_rready;
                if (s_rvalid && s_rready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any transaction and points round-robin at master 0 next.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= 3'(NUM_MASTERS - 1);
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Purpose: directed self-checking bench for axi_lite_mem_arbiter (RR, fixed priority, 3-master).
// Latency: inputs driven 1ns after the rising edge, outputs compared 2ns later.
// Backpressure: slave ready/valid driven directly from the stimulus sequence.
module tb_axi_lite_mem_arbiter;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Shared stimulus for the two 2-master instances.
    logic [1:0]  m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready;
    logic [63:0] m_awaddr, m_araddr, m_wdata;
    logic [5:0]  m_awprot, m_arprot;
    logic [7:0]  m_wstrb;
    logic        s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
    logic [31:0] s_rdata;

    // Round-robin instance outputs.
    logic [1:0]  a_m_awready, a_m_wready, a_m_arready, a_m_bvalid, a_m_rvalid;
    logic [63:0] a_m_rdata;
    logic        a_s_awvalid, a_s_wvalid, a_s_arvalid, a_s_bready, a_s_rready;
    logic [31:0] a_s_awaddr, a_s_araddr, a_s_wdata;
    logic [2:0]  a_s_awprot, a_s_arprot, a_grant_id;
    logic [3:0]  a_s_wstrb;
    logic        a_busy;

    // Fixed-priority instance outputs.
    logic [1:0]  b_m_awready, b_m_wready, b_m_arready, b_m_bvalid, b_m_rvalid;
    logic [63:0] b_m_rdata;
    logic        b_s_awvalid, b_s_wvalid, b_s_arvalid, b_s_bready, b_s_rready;
    logic [31:0] b_s_awaddr, b_s_araddr, b_s_wdata;
    logic [2:0]  b_s_awprot, b_s_arprot, b_grant_id;
    logic [3:0]  b_s_wstrb;
    logic        b_busy;

    // Three-master instance.
    logic [2:0]  c_m_arvalid, c_m_rready;
    logic [95:0] c_m_araddr;
    logic        c_s_arready, c_s_rvalid;
    logic [31:0] c_s_rdata;
    logic [2:0]  c_m_awready, c_m_wready, c_m_arready, c_m_bvalid, c_m_rvalid;
    logic [95:0] c_m_rdata;
    logic        c_s_awvalid, c_s_wvalid, c_s_arvalid, c_s_bready, c_s_rready;
    logic [31:0] c_s_awaddr, c_s_araddr, c_s_wdata;
    logic [2:0]  c_s_awprot, c_s_arprot, c_grant_id;
    logic [3:0]  c_s_wstrb;
    logic        c_busy;

    // Slave model for reads: returns the address it was given.
    assign s_rdata = a_s_araddr;

    axi_lite_mem_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIORITY_MODE(0)) dut_rr (
        .clk(clk), .resetn(resetn),
        .m_awvalid(m_awvalid), .m_wvalid(m_wvalid), .m_arvalid(m_arvalid), .m_bready(m_bready), .m_rready(m_rready),
        .m_awready(a_m_awready), .m_wready(a_m_wready), .m_arready(a_m_arready), .m_bvalid(a_m_bvalid), .m_rvalid(a_m_rvalid),
        .m_awaddr(m_awaddr), .m_araddr(m_araddr), .m_awprot(m_awprot), .m_arprot(m_arprot),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(a_m_rdata),
        .s_awvalid(a_s_awvalid), .s_wvalid(a_s_wvalid), .s_arvalid(a_s_arvalid), .s_bready(a_s_bready), .s_rready(a_s_rready),
        .s_awready(s_awready), .s_wready(s_wready), .s_arready(s_arready), .s_bvalid(s_bvalid), .s_rvalid(s_rvalid),
        .s_awaddr(a_s_awaddr), .s_araddr(a_s_araddr), .s_awprot(a_s_awprot), .s_arprot(a_s_arprot),
        .s_wdata(a_s_wdata), .s_wstrb(a_s_wstrb), .s_rdata(s_rdata),
        .grant_id(a_grant_id), .busy(a_busy)
    );

    axi_lite_mem_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIORITY_MODE(1)) dut_fp (
        .clk(clk), .resetn(resetn),
        .m_awvalid(m_awvalid), .m_wvalid(m_wvalid), .m_arvalid(m_arvalid), .m_bready(m_bready), .m_rready(m_rready),
        .m_awready(b_m_awready), .m_wready(b_m_wready), .m_arready(b_m_arready), .m_bvalid(b_m_bvalid), .m_rvalid(b_m_rvalid),
        .m_awaddr(m_awaddr), .m_araddr(m_araddr), .m_awprot(m_awprot), .m_arprot(m_arprot),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(b_m_rdata),
        .s_awvalid(b_s_awvalid), .s_wvalid(b_s_wvalid), .s_arvalid(b_s_arvalid), .s_bready(b_s_bready), .s_rready(b_s_rready),
        .s_awready(s_awready), .s_wready(s_wready), .s_arready(s_arready), .s_bvalid(s_bvalid), .s_rvalid(s_rvalid),
        .s_awaddr(b_s_awaddr), .s_araddr(b_s_araddr), .s_awprot(b_s_awprot), .s_arprot(b_s_arprot),
        .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb), .s_rdata(s_rdata),
        .grant_id(b_grant_id), .busy(b_busy)
    );

    axi_lite_mem_arbiter #(.NUM_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIORITY_MODE(0)) dut_m3 (
        .clk(clk), .resetn(resetn),
        .m_awvalid(3'b000), .m_wvalid(3'b000), .m_arvalid(c_m_arvalid), .m_bready(3'b000), .m_rready(c_m_rready),
        .m_awready(c_m_awready), .m_wready(c_m_wready), .m_arready(c_m_arready), .m_bvalid(c_m_bvalid), .m_rvalid(c_m_rvalid),
        .m_awaddr(96'h0), .m_araddr(c_m_araddr), .m_awprot(9'h0), .m_arprot(9'h0),
        .m_wdata(96'h0), .m_wstrb(12'h0), .m_rdata(c_m_rdata),
        .s_awvalid(c_s_awvalid), .s_wvalid(c_s_wvalid), .s_arvalid(c_s_arvalid), .s_bready(c_s_bready), .s_rready(c_s_rready),
        .s_awready(1'b0), .s_wready(1'b0), .s_arready(c_s_arready), .s_bvalid(1'b0), .s_rvalid(c_s_rvalid),
        .s_awaddr(c_s_awaddr), .s_araddr(c_s_araddr), .s_awprot(c_s_awprot), .s_arprot(c_s_arprot),
        .s_wdata(c_s_wdata), .s_wstrb(c_s_wstrb), .s_rdata(c_s_rdata),
        .grant_id(c_grant_id), .busy(c_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        m_awvalid = '0; m_wvalid = '0; m_arvalid = '0; m_bready = '0; m_rready = '0;
        m_awaddr = '0; m_araddr = '0; m_wdata = '0; m_awprot = '0; m_arprot = '0; m_wstrb = '0;
        s_awready = 0; s_wready = 0; s_arready = 0; s_bvalid = 0; s_rvalid = 0;
        c_m_arvalid = '0; c_m_rready = '0; c_m_araddr = '0;
        c_s_arready = 0; c_s_rvalid = 0; c_s_rdata = '0;
    endtask

    // One clock: land 1ns after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic rst();
        resetn = 1'b0;
        clr();
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        logic [2:0] e;
        resetn = 1'b0;
        clr();

        // ---- Reset state ----
        #2;
        chk("rst_busy", a_busy, 0);
        chk("rst_grant", a_grant_id, 0);
        chk("rst_s_valids", {a_s_awvalid, a_s_wvalid, a_s_arvalid, a_s_bready, a_s_rready}, 0);
        chk("rst_m_outs", {a_m_awready, a_m_wready, a_m_arready, a_m_bvalid, a_m_rvalid}, 0);

        // ---- Single write from M0, AW ready delayed two cycles, W ready at once ----
        rst();
        m_awvalid = 2'b01; m_wvalid = 2'b01; m_bready = 2'b01;
        m_awaddr = {32'h0000_0999, 32'h0000_0100};
        m_wdata  = {32'h1111_1111, 32'hDEAD_BEEF};
        m_wstrb  = 8'h3F; m_awprot = 6'b010_101;
        s_wready = 1; s_awready = 0;
        settle();
        chk("wr_idle_awvalid", a_s_awvalid, 0);
        chk("wr_idle_busy", a_busy, 0);
        cyc(); settle();
        chk("wr_grant", a_grant_id, 0);
        chk("wr_busy", a_busy, 1);
        chk("wr_s_awvalid", a_s_awvalid, 1);
        chk("wr_s_wvalid", a_s_wvalid, 1);
        chk("wr_s_awaddr", a_s_awaddr, 32'h100);
        chk("wr_s_wdata", a_s_wdata, 32'hDEADBEEF);
        chk("wr_s_wstrb", a_s_wstrb, 4'hF);
        chk("wr_s_awprot", a_s_awprot, 3'b101);
        chk("wr_m_wready", a_m_wready, 2'b01);
        chk("wr_m_awready_wait", a_m_awready, 2'b00);
        cyc(); m_wvalid = 2'b00; settle();
        chk("wr_w_done", a_s_wvalid, 0);
        chk("wr_aw_pending", a_s_awvalid, 1);
        cyc(); s_awready = 1; settle();
        chk("wr_m_awready", a_m_awready, 2'b01);
        chk("wr_m_wready_done", a_m_wready, 2'b00);
        cyc(); m_awvalid = 2'b00; s_awready = 0; settle();
        chk("wr_resp_awvalid", a_s_awvalid, 0);
        chk("wr_resp_bready", a_s_bready, 1);
        chk("wr_resp_bvalid_lo", a_m_bvalid, 2'b00);
        cyc(); s_bvalid = 1; settle();
        chk("wr_m_bvalid", a_m_bvalid, 2'b01);
        chk("wr_other_outs", {a_m_awready, a_m_wready, a_m_arready, a_m_rvalid}, 0);
        chk("wr_busy_b", a_busy, 1);
        cyc(); s_bvalid = 0; settle();
        chk("wr_busy_fall", a_busy, 0);
        chk("wr_grant_hold", a_grant_id, 0);

        // ---- Round-robin read contention: 4 reads each, expect 0,1,0,1,... ----
        rst();
        m_araddr = {32'h0000_0020, 32'h0000_0010};
        m_arvalid = 2'b11; m_rready = 2'b11; s_arready = 1; s_rvalid = 1;
        for (int t = 0; t < 8; t++) begin
            e = 3'(t % 2);
            settle();
            chk("rr_idle_busy", a_busy, 0);
            cyc(); settle();
            chk("rr_grant", a_grant_id, e);
            chk("rr_s_araddr", a_s_araddr, (e == 3'd1) ? 32'h20 : 32'h10);
            chk("rr_m_arready", a_m_arready, (e == 3'd1) ? 2'b10 : 2'b01);
            chk("rr_rvalid_early", a_m_rvalid, 2'b00);
            cyc(); settle();
            chk("rr_m_rvalid", a_m_rvalid, (e == 3'd1) ? 2'b10 : 2'b01);
            chk("rr_m_rdata", a_m_rdata[e*32 +: 32], (e == 3'd1) ? 32'h20 : 32'h10);
            cyc();
        end
        m_arvalid = 2'b00;

        // ---- Fixed priority: M1 starved while M0 keeps requesting ----
        rst();
        m_araddr = {32'h0000_0020, 32'h0000_0010};
        m_arvalid = 2'b11; m_rready = 2'b11; s_arready = 1; s_rvalid = 1;
        for (int t = 0; t < 3; t++) begin
            settle();
            cyc(); settle();
            chk("fp_grant_m0", b_grant_id, 0);
            chk("fp_s_araddr_m0", b_s_araddr, 32'h10);
            cyc();
            if (t == 2) m_arvalid = 2'b10;
            settle();
            chk("fp_m_rvalid_m0", b_m_rvalid, 2'b01);
            cyc();
        end
        settle();
        chk("fp_idle", b_busy, 0);
        cyc(); settle();
        chk("fp_grant_m1", b_grant_id, 1);
        chk("fp_s_araddr_m1", b_s_araddr, 32'h20);
        chk("fp_m_arready_m1", b_m_arready, 2'b10);
        m_arvalid = 2'b00;

        // ---- M1 asserts AW and AR together: write first, one IDLE, then read ----
        rst();
        m_awvalid = 2'b10; m_wvalid = 2'b10; m_arvalid = 2'b10;
        m_awaddr = {32'h0000_0200, 32'h0000_0AAA};
        m_araddr = {32'h0000_0300, 32'h0000_0BBB};
        m_wdata  = {32'h1234_5678, 32'h0};
        m_wstrb  = 8'h30; m_arprot = 6'b010_000;
        m_bready = 2'b10; m_rready = 2'b10;
        s_awready = 1; s_wready = 1; s_bvalid = 1; s_arready = 1; s_rvalid = 1;
        settle();
        chk("aa_idle_busy", a_busy, 0);
        cyc(); settle();
        chk("aa_grant_w", a_grant_id, 1);
        chk("aa_s_awvalid", a_s_awvalid, 1);
        chk("aa_s_awaddr", a_s_awaddr, 32'h200);
        chk("aa_s_wdata", a_s_wdata, 32'h12345678);
        chk("aa_s_wstrb", a_s_wstrb, 4'h3);
        chk("aa_no_arvalid", a_s_arvalid, 0);
        chk("aa_m_awready", a_m_awready, 2'b10);
        cyc(); m_awvalid = 2'b00; m_wvalid = 2'b00; settle();
        chk("aa_m_bvalid", a_m_bvalid, 2'b10);
        chk("aa_s_bready", a_s_bready, 1);
        cyc(); settle();
        chk("aa_gap_busy", a_busy, 0);
        chk("aa_gap_arvalid", a_s_arvalid, 0);
        cyc(); settle();
        chk("aa_grant_r", a_grant_id, 1);
        chk("aa_s_arvalid", a_s_arvalid, 1);
        chk("aa_s_araddr", a_s_araddr, 32'h300);
        chk("aa_s_arprot", a_s_arprot, 3'b010);
        chk("aa_m_arready", a_m_arready, 2'b10);
        cyc(); m_arvalid = 2'b00; settle();
        chk("aa_m_rvalid", a_m_rvalid, 2'b10);
        chk("aa_m_rdata", a_m_rdata[63:32], 32'h300);
        cyc(); settle();
        chk("aa_done_busy", a_busy, 0);

        // ---- Asynchronous reset while in WR_RESP with bvalid up ----
        rst();
        m_awvalid = 2'b10; m_wvalid = 2'b10; m_awaddr = {32'h0000_0080, 32'h0};
        s_awready = 1; s_wready = 1;
        settle();
        cyc(); settle();
        chk("ar_wr_addr", a_s_awvalid, 1);
        cyc(); m_awvalid = 2'b00; m_wvalid = 2'b00; settle();
        chk("ar_in_resp", a_busy, 1);
        chk("ar_bvalid_lo", a_m_bvalid, 2'b00);
        s_bvalid = 1; m_bready = 2'b10;
        #1;
        chk("ar_bvalid_hi", a_m_bvalid, 2'b10);
        chk("ar_bready_hi", a_s_bready, 1);
        resetn = 1'b0;
        #1;
        chk("ar_bvalid_async", a_m_bvalid, 2'b00);
        chk("ar_bready_async", a_s_bready, 0);
        chk("ar_busy_async", a_busy, 0);
        chk("ar_grant_async", a_grant_id, 0);
        @(posedge clk); #1;
        chk("ar_bvalid_held", a_m_bvalid, 2'b00);
        resetn = 1'b1;
        clr();
        m_arvalid = 2'b11; m_rready = 2'b11; s_arready = 1;
        settle();
        chk("ar_post_bvalid", a_m_bvalid, 2'b00);
        cyc(); settle();
        chk("ar_post_grant", a_grant_id, 0);
        chk("ar_post_arvalid", a_s_arvalid, 1);
        chk("ar_post_bvalid2", a_m_bvalid, 2'b00);

        // ---- Three masters: M2 alone reads 0x40 ----
        rst();
        c_m_arvalid = 3'b100; c_m_rready = 3'b100;
        c_m_araddr = {32'h0000_0040, 32'h0000_0555, 32'h0000_0666};
        c_s_arready = 1; c_s_rvalid = 1; c_s_rdata = 32'hCAFE_0040;
        settle();
        cyc(); settle();
        chk("m3_grant", c_grant_id, 2);
        chk("m3_s_arvalid", c_s_arvalid, 1);
        chk("m3_s_araddr", c_s_araddr, 32'h40);
        chk("m3_m_arready", c_m_arready, 3'b100);
        cyc(); c_m_arvalid = 3'b000; settle();
        chk("m3_m_rvalid", c_m_rvalid, 3'b100);
        chk("m3_rdata_m2", c_m_rdata[95:64], 32'hCAFE0040);
        chk("m3_rdata_m0", c_m_rdata[31:0], 32'hCAFE0040);
        cyc(); settle();
        chk("m3_busy_done", c_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
